// File: rtl/dff_reg_arbiter_if.sv
// dff_reg_arbiter_if: request/grant/data bundle between N requesters and the
//   shared-register arbiter. Optional burst-hold field lock exists only when
//   DFF_ARB_LOCK_EN is defined.
// Ports (as fields): req[N], din[N*WIDTH], lock[N] (requester -> arbiter);
//   gnt[N], q[WIDTH], owner[$clog2(N)], valid (arbiter -> requesters).
// Modports: master = requester side, slave = arbiter side.
interface dff_reg_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  logic [N-1:0]         req;
  logic [N*WIDTH-1:0]   din;
`ifdef DFF_ARB_LOCK_EN
  logic [N-1:0]         lock;
`endif
  logic [N-1:0]         gnt;
  logic [WIDTH-1:0]     q;
  logic [$clog2(N)-1:0] owner;
  logic                 valid;

  modport master (
    output req, din,
`ifdef DFF_ARB_LOCK_EN
    output lock,
`endif
    input  gnt, q, owner, valid
  );

  modport slave (
    input  req, din,
`ifdef DFF_ARB_LOCK_EN
    input  lock,
`endif
    output gnt, q, owner, valid
  );
endinterface

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: round-robin arbiter that is the sole writer of one shared
//   WIDTH-bit register. Grant registered in IDLE, write on the following edge
//   if the granted requester still requests (else the write is cancelled).
// Latency: REQ at edge t -> GNT during [t,t+1) -> Q updated at edge t+1.
// Backpressure: one write per 2 cycles; with DFF_ARB_LOCK_EN defined, a
//   requester holding REQ&LOCK keeps the grant and writes every cycle.
// Ports: i_clk, i_rst (async active-high), bus (dff_reg_arbiter_if.slave).
module dff_reg_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  dff_reg_arbiter_if.slave bus
);
  localparam int PW = $clog2(N);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [N-1:0]     r_gnt;
  logic [PW-1:0]    r_sel;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_owner;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;

  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_pick;
  logic [N-1:0]     w_pick_oh;
  logic [WIDTH-1:0] w_din_sel;
  logic             w_sel_req;
  logic             w_hold;

  // Round-robin pick: scan from the farthest candidate back to r_ptr+1 so the
  // last hit (nearest to r_ptr+1) wins.
  always_comb begin
    w_pick = '0;
    w_idx  = '0;
    for (int j = N; j >= 1; j--) begin
      w_idx = PW'((int'(r_ptr) + j) % N);
      if (bus.req[w_idx]) w_pick = w_idx;
    end
  end

  always_comb begin
    w_pick_oh         = '0;
    w_pick_oh[w_pick] = 1'b1;
  end

  always_comb begin
    w_din_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (r_sel == PW'(i)) w_din_sel = bus.din[i*WIDTH +: WIDTH];
    end
  end

  // r_gnt is one-hot on r_sel while BUSY, so masking REQ with it gives REQ[k].
  assign w_sel_req = |(bus.req & r_gnt);

`ifdef DFF_ARB_LOCK_EN
  assign w_hold = |(bus.req & bus.lock & r_gnt);
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= PW'(N - 1);
      r_owner <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (|bus.req) begin
        r_gnt   <= w_pick_oh;
        r_sel   <= w_pick;
        r_state <= S_BUSY;
      end else begin
        r_gnt   <= '0;
      end
    end else begin
      if (w_sel_req) begin
        r_q     <= w_din_sel;
        r_owner <= r_sel;
        r_valid <= 1'b1;
        r_ptr   <= r_sel;
      end
      // A withdrawn request cancels the write but still releases the grant.
      if (!w_hold) begin
        r_gnt   <= '0;
        r_state <= S_IDLE;
      end
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.q     = r_q;
  assign bus.owner = r_owner;
  assign bus.valid = r_valid;
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// tb_dff_reg_arbiter: scoreboard bench for dff_reg_arbiter (N=4, WIDTH=8).
// A reference model steps on every clock edge and queues the expected
// outputs; a monitor on the falling edge pops and compares them.
module tb_dff_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [W-1:0] q;
    logic [1:0]   own;
    logic         val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dff_reg_arbiter_if #(.N(N), .WIDTH(W)) bus ();

  dff_reg_arbiter #(.N(N), .WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  // Reference model: cur = granted requester index, -1 when nobody is granted.
  int       m_cur = -1;
  int       m_ptr = N - 1;
  logic [7:0] m_q = '0;
  int       m_own = 0;
  logic     m_val = 1'b0;

  logic [N-1:0] lk;
`ifdef DFF_ARB_LOCK_EN
  assign lk = bus.lock;
`else
  assign lk = '0;
`endif

  function automatic exp_t model_out();
    exp_t e;
    e.gnt = (m_cur < 0) ? 4'b0000 : 4'(1 << m_cur);
    e.q   = m_q;
    e.own = 2'(m_own);
    e.val = m_val;
    return e;
  endfunction

  task automatic model_step(input logic [N-1:0] req, input logic [N*W-1:0] din,
                            input logic [N-1:0] lock);
    if (m_cur < 0) begin
      for (int j = 1; j <= N; j++) begin
        int c;
        c = (m_ptr + j) % N;
        if (req[c]) begin
          m_cur = c;
          break;
        end
      end
    end else if (req[m_cur]) begin
      m_q   = din[m_cur*W +: W];
      m_own = m_cur;
      m_val = 1'b1;
      m_ptr = m_cur;
      if (!lock[m_cur]) m_cur = -1;
    end else begin
      m_cur = -1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur = -1; m_ptr = N - 1; m_q = '0; m_own = 0; m_val = 1'b0;
      sb.delete();
    end else begin
      model_step(bus.req, bus.din, lk);
    end
    sb.push_back(model_out());
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (bus.gnt !== e.gnt || bus.q !== e.q || bus.owner !== e.own || bus.valid !== e.val) begin
        n_err++;
        $display("FAIL scoreboard t=%0t: got gnt=%b q=%h own=%0d val=%b, expected gnt=%b q=%h own=%0d val=%b",
                 $time, bus.gnt, bus.q, bus.owner, bus.valid, e.gnt, e.q, e.own, e.val);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] g, input logic [7:0] q,
                         input logic [1:0] o, input logic v);
    chk({name, ".gnt"},   32'(bus.gnt),   32'(g));
    chk({name, ".q"},     32'(bus.q),     32'(q));
    chk({name, ".owner"}, 32'(bus.owner), 32'(o));
    chk({name, ".valid"}, 32'(bus.valid), 32'(v));
  endtask

  initial begin
    logic [3:0] eg;
    bus.req = '0;
    bus.din = $urandom;
`ifdef DFF_ARB_LOCK_EN
    bus.lock = '0;
`endif
    // Reset state with arbitrary data, then idle cycles.
    repeat (2) @(negedge clk);
    chk_out("reset", 4'b0000, 8'h00, 2'd0, 1'b0);
    rst = 1'b0;
    bus.din = '0;
    repeat (5) @(negedge clk);
    chk_out("idle5", 4'b0000, 8'h00, 2'd0, 1'b0);

    // Round robin with all requesters active.
    bus.req = 4'b1111;
    bus.din = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      eg = 4'b0001 << (i % 4);
      chk("rr.gnt", 32'(bus.gnt), 32'(eg));
      @(negedge clk);
      chk("rr.q", 32'(bus.q), 32'(8'h10 + (i % 4)));
      chk("rr.gnt_idle", 32'(bus.gnt), 32'h0);
    end
    bus.req = '0;

    // Single write.
    @(negedge clk);
    bus.req = 4'b0100;
    bus.din[23:16] = 8'hA5;
    @(negedge clk);
    chk("single.gnt", 32'(bus.gnt), 32'h4);
    @(negedge clk);
    chk_out("single", 4'b0000, 8'hA5, 2'd2, 1'b1);
    bus.req = '0;

    // Withdraw while granted.
    @(negedge clk);
    bus.req = 4'b0010;
    bus.din[15:8] = 8'h3C;
    @(negedge clk);
    chk("withdraw.gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    @(negedge clk);
    chk_out("withdraw", 4'b0000, 8'hA5, 2'd2, 1'b1);

    // Asynchronous reset in the middle of a grant.
    bus.req = 4'b1000;
    bus.din[31:24] = 8'h5A;
    @(posedge clk);
    #2;
    chk("rstmid.pre_gnt", 32'(bus.gnt), 32'h8);
    rst = 1'b1;
    #1;
    chk_out("rstmid", 4'b0000, 8'h00, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid.regrant", 32'(bus.gnt), 32'h8);
    @(negedge clk);
    chk_out("rstmid.write", 4'b0000, 8'h5A, 2'd3, 1'b1);
    bus.req = '0;

`ifdef DFF_ARB_LOCK_EN
    // Locked burst by requester 3 while requester 0 waits.
    @(negedge clk);
    bus.req = 4'b1000;
    @(negedge clk);
    bus.req = 4'b1001;
    bus.lock = 4'b1000;
    bus.din[31:24] = 8'h11;
    @(negedge clk);
    chk("lock.q1", 32'(bus.q), 32'h11);
    chk("lock.gnt1", 32'(bus.gnt), 32'h8);
    bus.din[31:24] = 8'h22;
    @(negedge clk);
    chk("lock.q2", 32'(bus.q), 32'h22);
    chk("lock.gnt2", 32'(bus.gnt), 32'h8);
    bus.din[31:24] = 8'h33;
    bus.lock = 4'b0000;
    @(negedge clk);
    chk("lock.q3", 32'(bus.q), 32'h33);
    chk("lock.gnt3", 32'(bus.gnt), 32'h0);
    @(negedge clk);
    chk("lock.next", 32'(bus.gnt), 32'h1);
    bus.req = '0;
`endif

    // Randomized traffic; requests tend to persist so bursts and withdrawals
    // both occur, with occasional asynchronous resets.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      else if ($urandom_range(0, 3) == 0) bus.req = bus.req & 4'($urandom);
      bus.din = $urandom;
`ifdef DFF_ARB_LOCK_EN
      bus.lock = ($urandom_range(0, 2) == 0) ? 4'($urandom) : bus.lock;
`endif
      if ($urandom_range(0, 99) == 0) begin
        #3 rst = 1'b1;
        @(negedge clk);
        #3 rst = 1'b0;
      end
    end
    bus.req = '0;
    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
